// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with an output FIFO.
//
// Frames are captured by an oversampling FSM and pushed into a small FIFO as
// {data, perr, ferr}. The downstream consumer pops them with a valid/ready
// handshake. Errored frames are still pushed; the consumer decides what to do.
//
// Parameters:
//   DATA_BITS    data bits per frame (5..9), LSB first
//   CLKS_PER_BIT clk cycles per bit (>= 8)
//   PARITY_MODE  0 = none, 1 = even, 2 = odd
//   STOP_BITS    1 or 2
//   FIFO_DEPTH   FIFO entries, power of two, >= 2
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   Rx        serial line, idles high, asynchronous to clk
//   rx_data   data of the FIFO head entry
//   rx_perr   parity error flag of the head entry
//   rx_ferr   framing error flag of the head entry
//   rx_valid  FIFO non-empty
//   rx_ready  consumer accepts the head entry
//   overrun   one-cycle pulse when a completed frame is dropped (FIFO full)
//
// Build option:
//   UART_RX_MAJORITY_EN  when defined, every bit is a 2-of-3 vote of samples at
//                        mid-1, mid and mid+1, decided at mid+1. All sample points
//                        and the commit move one cycle later. When undefined, each
//                        bit is a single sample at mid.

module uart_rx_param #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 32,
  parameter int unsigned PARITY_MODE  = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun
);

`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned MajOffs = 1;
`else
  localparam int unsigned MajOffs = 0;
`endif

  localparam int unsigned CntW    = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned BitCntW = 4;
  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned EntW    = DATA_BITS + 2;

  // Start bit is decided half a bit after the edge; later bits one full bit apart.
  localparam logic [CntW-1:0]    StartPoint = CntW'(CLKS_PER_BIT / 2 + MajOffs);
  localparam logic [CntW-1:0]    BitPoint   = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitCntW-1:0] LastData   = BitCntW'(DATA_BITS - 1);
  localparam logic [BitCntW-1:0] LastStop   = BitCntW'(STOP_BITS - 1);
  localparam logic               HasParity  = (PARITY_MODE != 0);
  localparam logic               OddParity  = (PARITY_MODE == 2);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  // ---------------------------------------------------------------------------
  // Input synchroniser and start-edge detect
  // ---------------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q, rx_prev_q;
  logic start_edge;
  logic bit_val;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= Rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign start_edge = rx_prev_q & ~rx_sync_q;

`ifdef UART_RX_MAJORITY_EN
  // win_q[0] holds the sample one cycle back, win_q[1] two cycles back, so at
  // the decision count (mid+1) the three votes are mid-1, mid and mid+1.
  logic [1:0] win_q, win_d;

  assign win_d = {win_q[0], rx_sync_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_q <= 2'b11;
    end else begin
      win_q <= win_d;
    end
  end

  assign bit_val = (rx_sync_q & win_q[0]) | (rx_sync_q & win_q[1]) | (win_q[0] & win_q[1]);
`else
  assign bit_val = rx_sync_q;
`endif

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  logic [2:0]           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 commit;
  logic [EntW-1:0]      commit_ent;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    commit     = 1'b0;
    // Include the current stop sample so the last stop bit counts immediately.
    commit_ent = {shreg_q, perr_q, ferr_q | ~bit_val};

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start_edge) begin
          state_d   = StStart;
          bit_cnt_d = '0;
        end
      end

      StStart: begin
        if (cnt_q == StartPoint) begin
          cnt_d = '0;
          if (bit_val) begin
            // Line is high again at mid-bit: the edge was a glitch.
            state_d = StIdle;
          end else begin
            state_d   = StData;
            bit_cnt_d = '0;
            perr_d    = 1'b0;
            ferr_d    = 1'b0;
          end
        end
      end

      StData: begin
        if (cnt_q == BitPoint) begin
          cnt_d     = '0;
          shreg_d   = {bit_val, shreg_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LastData) begin
            bit_cnt_d = '0;
            state_d   = HasParity ? StParity : StStop;
          end
        end
      end

      StParity: begin
        if (cnt_q == BitPoint) begin
          cnt_d   = '0;
          // Even parity: total ones (data + parity bit) must be even; odd inverts.
          perr_d  = bit_val ^ (^shreg_q) ^ OddParity;
          state_d = StStop;
        end
      end

      StStop: begin
        if (cnt_q == BitPoint) begin
          cnt_d     = '0;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (!bit_val) begin
            ferr_d = 1'b1;
          end
          if (bit_cnt_q == LastStop) begin
            commit    = 1'b1;
            bit_cnt_d = '0;
            state_d   = StIdle;
          end
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO (no bypass; extra pointer bit separates full from empty)
  // ---------------------------------------------------------------------------
  logic [EntW-1:0] mem_q [FIFO_DEPTH];
  logic [EntW-1:0] mem_d [FIFO_DEPTH];
  logic [PtrW:0]   wptr_q, wptr_d;
  logic [PtrW:0]   rptr_q, rptr_d;
  logic            overrun_q, overrun_d;
  logic            fifo_empty, fifo_full;
  logic            push, pop;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                      (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);

  assign pop  = ~fifo_empty & rx_ready;
  // A pop in the commit cycle frees the slot that the push reuses.
  assign push = commit & (~fifo_full | pop);

  always_comb begin
    mem_d     = mem_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    overrun_d = commit & fifo_full & ~pop;
    if (push) begin
      mem_d[wptr_q[PtrW-1:0]] = commit_ent;
      wptr_d                  = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q     <= '{default: '0};
      wptr_q    <= '0;
      rptr_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      overrun_q <= overrun_d;
    end
  end

  assign {rx_data, rx_perr, rx_ferr} = mem_q[rptr_q[PtrW-1:0]];
  assign rx_valid                    = ~fifo_empty;
  assign overrun                     = overrun_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: one instance with even parity (_p), one without (_n).
// Each task drives its scenario and checks outputs against values computed from
// the frame contents (ones counts, expected-entry queues).

module tb_uart_rx_param;

  localparam int BitNs = 320;

  logic clk = 1'b0;
  logic rst;

  logic       rx_p, rdy_p, perr_p, ferr_p, val_p, ov_p;
  logic [7:0] data_p;
  logic       rx_n, rdy_n, perr_n, ferr_n, val_n, ov_n;
  logic [7:0] data_n;

  int n_vec = 0;
  int n_err = 0;
  int ovr_p = 0;
  int ovr_n = 0;

  always #5 clk = ~clk;

  uart_rx_param #(
    .DATA_BITS   (8),
    .CLKS_PER_BIT(32),
    .PARITY_MODE (1),
    .STOP_BITS   (1),
    .FIFO_DEPTH  (4)
  ) dut_p (
    .clk     (clk),
    .rst     (rst),
    .Rx      (rx_p),
    .rx_data (data_p),
    .rx_perr (perr_p),
    .rx_ferr (ferr_p),
    .rx_valid(val_p),
    .rx_ready(rdy_p),
    .overrun (ov_p)
  );

  uart_rx_param #(
    .DATA_BITS   (8),
    .CLKS_PER_BIT(32),
    .PARITY_MODE (0),
    .STOP_BITS   (1),
    .FIFO_DEPTH  (4)
  ) dut_n (
    .clk     (clk),
    .rst     (rst),
    .Rx      (rx_n),
    .rx_data (data_n),
    .rx_perr (perr_n),
    .rx_ferr (ferr_n),
    .rx_valid(val_n),
    .rx_ready(rdy_n),
    .overrun (ov_n)
  );

  // Overrun pulses are counted on the active edge; checks happen on negedges.
  always @(posedge clk) begin
    if (ov_p === 1'b1) ovr_p = ovr_p + 1;
    if (ov_n === 1'b1) ovr_n = ovr_n + 1;
  end

  task automatic set_line(input bit to_p, input logic v);
    if (to_p) rx_p = v;
    else      rx_n = v;
  endtask

  // Start, 8 data bits LSB first, optional parity, one stop, then one idle bit.
  task automatic send_frame(input bit to_p, input logic [7:0] d, input bit with_par,
                            input logic pbit, input logic stopv);
    set_line(to_p, 1'b0);
    #BitNs;
    for (int i = 0; i < 8; i++) begin
      set_line(to_p, d[i]);
      #BitNs;
    end
    if (with_par) begin
      set_line(to_p, pbit);
      #BitNs;
    end
    set_line(to_p, stopv);
    #BitNs;
    set_line(to_p, 1'b1);
    #BitNs;
  endtask

  task automatic pop_one(input bit to_p);
    if (to_p) rdy_p = 1'b1;
    else      rdy_n = 1'b1;
    #10;
    rdy_p = 1'b0;
    rdy_n = 1'b0;
  endtask

  task automatic test_reset;
    n_vec++; if (val_p !== 1'b0) begin n_err++; $display("FAIL reset_valid_p got %b exp 0", val_p); end
    n_vec++; if (val_n !== 1'b0) begin n_err++; $display("FAIL reset_valid_n got %b exp 0", val_n); end
    n_vec++; if (data_p !== 8'h00) begin n_err++; $display("FAIL reset_data_p got %h exp 00", data_p); end
    n_vec++; if (data_n !== 8'h00) begin n_err++; $display("FAIL reset_data_n got %h exp 00", data_n); end
    n_vec++; if ({perr_p, ferr_p, ov_p} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags_p got %b exp 000", {perr_p, ferr_p, ov_p}); end
    n_vec++; if ({perr_n, ferr_n, ov_n} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags_n got %b exp 000", {perr_n, ferr_n, ov_n}); end
  endtask

  task automatic test_parity;
    send_frame(1'b1, 8'h90, 1'b1, 1'b0, 1'b1);
    n_vec++; if (val_p !== 1'b1) begin n_err++; $display("FAIL par_ok_valid got %b exp 1", val_p); end
    n_vec++; if (data_p !== 8'h90) begin n_err++; $display("FAIL par_ok_data got %h exp 90", data_p); end
    n_vec++; if ({perr_p, ferr_p} !== 2'b00) begin
      n_err++; $display("FAIL par_ok_flags got %b exp 00", {perr_p, ferr_p}); end
    pop_one(1'b1);
    n_vec++; if (val_p !== 1'b0) begin n_err++; $display("FAIL par_ok_pop got %b exp 0", val_p); end
    send_frame(1'b1, 8'h90, 1'b1, 1'b1, 1'b1);
    n_vec++; if (val_p !== 1'b1) begin n_err++; $display("FAIL par_bad_valid got %b exp 1", val_p); end
    n_vec++; if (data_p !== 8'h90) begin n_err++; $display("FAIL par_bad_data got %h exp 90", data_p); end
    n_vec++; if ({perr_p, ferr_p} !== 2'b10) begin
      n_err++; $display("FAIL par_bad_flags got %b exp 10", {perr_p, ferr_p}); end
    pop_one(1'b1);
  endtask

  task automatic test_back_to_back;
    send_frame(1'b0, 8'h75, 1'b0, 1'b0, 1'b1);
    #2000;
    send_frame(1'b0, 8'h91, 1'b0, 1'b0, 1'b1);
    n_vec++; if (data_n !== 8'h75) begin n_err++; $display("FAIL b2b_first got %h exp 75", data_n); end
    n_vec++; if ({val_n, perr_n, ferr_n} !== 3'b100) begin
      n_err++; $display("FAIL b2b_first_flags got %b exp 100", {val_n, perr_n, ferr_n}); end
    pop_one(1'b0);
    n_vec++; if (data_n !== 8'h91) begin n_err++; $display("FAIL b2b_second got %h exp 91", data_n); end
    n_vec++; if ({val_n, perr_n, ferr_n} !== 3'b100) begin
      n_err++; $display("FAIL b2b_second_flags got %b exp 100", {val_n, perr_n, ferr_n}); end
    pop_one(1'b0);
    n_vec++; if (val_n !== 1'b0) begin n_err++; $display("FAIL b2b_empty got %b exp 0", val_n); end
  endtask

  task automatic test_framing;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
    n_vec++; if (data_n !== 8'hA5) begin n_err++; $display("FAIL ferr_data got %h exp a5", data_n); end
    n_vec++; if ({val_n, perr_n, ferr_n} !== 3'b101) begin
      n_err++; $display("FAIL ferr_flags got %b exp 101", {val_n, perr_n, ferr_n}); end
    pop_one(1'b0);
  endtask

  task automatic test_glitch;
    rx_n = 1'b0;
    #100;
    rx_n = 1'b1;
    #1000;
    n_vec++; if (val_n !== 1'b0) begin n_err++; $display("FAIL glitch_push got %b exp 0", val_n); end
  endtask

  // Fill a depth-4 FIFO with random frames, overflow with a 5th, then drain.
  task automatic test_overrun;
    logic [7:0] q[$];
    logic [7:0] d;
    int         ov0;
    ov0 = ovr_n;
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom_range(0, 255));
      if (i < 4) q.push_back(d);
      send_frame(1'b0, d, 1'b0, 1'b0, 1'b1);
      if (i == 3) begin
        n_vec++; if (ovr_n !== ov0) begin
          n_err++; $display("FAIL ovr_early got %0d exp %0d", ovr_n, ov0); end
      end
    end
    n_vec++; if (ovr_n !== ov0 + 1) begin
      n_err++; $display("FAIL ovr_pulse got %0d exp %0d", ovr_n, ov0 + 1); end
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (val_n !== 1'b1 || data_n !== q[i]) begin
        n_err++; $display("FAIL ovr_drain%0d got %b/%h exp 1/%h", i, val_n, data_n, q[i]); end
      pop_one(1'b0);
    end
    n_vec++; if (val_n !== 1'b0) begin n_err++; $display("FAIL ovr_empty got %b exp 0", val_n); end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] d;
    int         ov0;
    for (int i = 0; i < 2; i++) send_frame(1'b0, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b1);
    n_vec++; if (val_n !== 1'b1) begin n_err++; $display("FAIL rmid_pre got %b exp 1", val_n); end
    d = 8'($urandom_range(0, 255));
    rx_n = 1'b0;
    #BitNs;
    for (int i = 0; i < 3; i++) begin
      rx_n = d[i];
      #BitNs;
    end
    #160;
    rst  = 1'b0;
    rx_n = 1'b1;
    #10;
    rst = 1'b1;
    n_vec++; if (val_n !== 1'b0) begin n_err++; $display("FAIL rmid_valid got %b exp 0", val_n); end
    ov0 = ovr_n;
    #(10 * BitNs);
    n_vec++; if (val_n !== 1'b0) begin n_err++; $display("FAIL rmid_spurious got %b exp 0", val_n); end
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    n_vec++; if (data_n !== 8'h3C) begin n_err++; $display("FAIL rmid_3c got %h exp 3c", data_n); end
    n_vec++; if ({val_n, perr_n, ferr_n} !== 3'b100) begin
      n_err++; $display("FAIL rmid_3c_flags got %b exp 100", {val_n, perr_n, ferr_n}); end
    n_vec++; if (ovr_n !== ov0) begin n_err++; $display("FAIL rmid_ovr got %0d exp %0d", ovr_n, ov0); end
    pop_one(1'b0);
  endtask

  // Random data, parity bit and stop bit; expected flags from ones counts.
  task automatic test_random_parity;
    logic [9:0] q[$];
    logic [7:0] d;
    logic       pbit, stopv;
    int         n;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        d     = 8'($urandom_range(0, 255));
        pbit  = 1'($urandom_range(0, 1));
        stopv = ($urandom_range(0, 3) != 0);
        q.push_back({d, 1'((($countones(d) + int'(pbit)) % 2) != 0), ~stopv});
        send_frame(1'b1, d, 1'b1, pbit, stopv);
      end
      while (q.size() > 0) begin
        n_vec++; if ({val_p, data_p, perr_p, ferr_p} !== {1'b1, q[0]}) begin
          n_err++; $display("FAIL rand_entry got %b_%h_%b%b exp 1_%h_%b%b", val_p, data_p,
                            perr_p, ferr_p, q[0][9:2], q[0][1], q[0][0]); end
        void'(q.pop_front());
        pop_one(1'b1);
      end
      n_vec++; if (val_p !== 1'b0) begin n_err++; $display("FAIL rand_empty got %b exp 0", val_p); end
    end
    n_vec++; if (ovr_p !== 0) begin n_err++; $display("FAIL rand_ovr got %0d exp 0", ovr_p); end
  endtask

  initial begin
    rst   = 1'b0;
    rx_p  = 1'b1;
    rx_n  = 1'b1;
    rdy_p = 1'b0;
    rdy_n = 1'b0;
    @(negedge clk);
    #30;
    test_reset();
    rst = 1'b1;
    #100;
    test_parity();
    test_back_to_back();
    test_framing();
    test_glitch();
    test_overrun();
    test_reset_mid_frame();
    test_random_parity();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver, the successor of the fixed 8-bit, 32-clocks-per-bit receiver that feeds the address decoder. It supports configurable data width, oversampling ratio, parity mode and stop-bit count. Each received frame goes into a small output FIFO together with its parity-error and framing-error flags, and is handed to the downstream frame processor with a valid/ready handshake.

## Interface
Parameters:
- DATA_BITS, 8: data bits per frame; legal range 5..9; sent LSB first.
- CLKS_PER_BIT, 32: clk cycles per bit; minimum 8.
- PARITY_MODE, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: number of FIFO entries; must be a power of two, minimum 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- Rx  in  1  serial line; idles high; asynchronous to clk.
- rx_data  out  DATA_BITS  data at the FIFO head.
- rx_perr  out  1  parity error flag of the head entry; always 0 when PARITY_MODE = 0.
- rx_ferr  out  1  framing error flag of the head entry.
- rx_valid  out  1  FIFO is non-empty.
- rx_ready  in  1  consumer accepts the head entry.
- overrun  out  1  one-cycle pulse when a completed frame is dropped because the FIFO is full.

## Operation
Input stage:
- Rx passes through a 2-flop synchroniser. Both flops reset to 1.
- A start edge is a 1→0 transition on the synchronised line.

State machine: IDLE → START → DATA → PARITY → STOP → IDLE.
- PARITY is skipped when PARITY_MODE = 0.
- IDLE: wait for a start edge. On the edge, clear the bit counter and go to START.
- START: at count CLKS_PER_BIT/2, take the sample.
  - Sample = 1: the edge was a glitch. Return to IDLE; nothing is pushed.
  - Sample = 0: restart the count and go to DATA.
- DATA: take a sample every CLKS_PER_BIT cycles, at mid-bit. Shift the samples in LSB first. After DATA_BITS samples, move on.
- PARITY: one mid-bit sample.
  - perr = received bit XOR (XOR of all data bits), with the expected value inverted for odd parity.
  - In other words, even parity requires the total count of 1s to be even; odd parity requires it to be odd.
- STOP: STOP_BITS samples.
  - ferr = 1 if any stop sample is 0.
  - At the last stop sample, the frame {data, perr, ferr} is committed and the FSM returns to IDLE.
  - A new start edge is accepted from the next cycle.
- A frame with an error is still pushed. The consumer decides what to do with it.

FIFO:
- Push happens on commit.
- Pop happens when rx_valid && rx_ready.
- If the FIFO is full at commit and no pop happens in the same cycle, the frame is dropped and overrun pulses for one cycle.
- If the FIFO is full and a pop happens in the same cycle as the commit, the push succeeds and there is no overrun.
- Read and write pointers wrap modulo FIFO_DEPTH. An extra pointer bit distinguishes full from empty.

Reset:
- Asserting rst mid-frame aborts the frame immediately. The FIFO is emptied and the FSM returns to IDLE.
- Reset values: rx_data = 0, rx_perr = 0, rx_ferr = 0, rx_valid = 0, overrun = 0.

## Timing
- Sample point: count CLKS_PER_BIT/2 after the synchronised start edge, then every CLKS_PER_BIT after that.
- Rx-to-FSM latency: 2 cycles, through the synchroniser.
- Commit to rx_valid: rx_valid rises on the clock edge after commit when the FIFO was empty.
- rx_data, rx_perr and rx_ferr are driven straight from the FIFO head. They are stable while rx_valid = 1 and rx_ready = 0.
- Pop: the head advances on the edge where rx_valid && rx_ready. rx_valid drops on that edge if it was the last entry.
- The FIFO does not bypass: a frame committed into an empty FIFO cannot be popped in its commit cycle.
- Frame length: (1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS) × CLKS_PER_BIT cycles.

## Configuration
- UART_RX_MAJORITY_EN defined:
  - Every bit, including start, parity and stop, is decided by a 2-of-3 majority vote.
  - The three samples are taken at mid−1, mid and mid+1. The decision is taken at mid+1.
  - All sample points, and the commit, therefore move one cycle later.
- UART_RX_MAJORITY_EN undefined: every bit is a single sample at mid.

## Test plan
All scenarios use clk period 10 ns and CLKS_PER_BIT = 32 (320 ns per bit).
- Reset, then DATA_BITS = 8, PARITY_MODE = 1. Send 0x90 with parity bit 0 and stop 1.
  - Expect rx_valid = 1, rx_data = 0x90, perr = 0, ferr = 0.
- PARITY_MODE = 1. Send 0x90 with parity bit 1.
  - Expect rx_data = 0x90, perr = 1. The frame is still delivered.
- PARITY_MODE = 0. Send 0x75 and 0x91 back to back, 2000 ns apart, with rx_ready held at 0.
  - Expect two entries, delivered in order: 0x75 then 0x91. Both flags are 0.
- Send 0xA5 with the stop bit driven 0.
  - Expect ferr = 1 and rx_data = 0xA5.
- Drive a 100 ns low pulse on an idle Rx line.
  - Expect no push; the FSM is back in IDLE.
- FIFO_DEPTH = 4, rx_ready = 0. Send 5 frames.
  - Expect 4 entries and one overrun pulse at the 5th commit.
  - Then raise rx_ready: the 4 frames drain in order.
- Repeat the test above with a 1-cycle rst assertion in the middle of frame 3.
  - Expect rx_valid = 0 immediately after the reset.
  - Then send 0x3C: it is received correctly.
